ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: it sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) from the FPGA to the keyboard. It performs the request-to-send sequence, then shifts out start bit, 8 data bits LSB-first, odd parity and stop bit under the device-generated clock, and checks the device ACK. It sits beside the PS/2 receiver on the same `ps2_clk`/`ps2_data` pins. Both lines are open-drain; this block only ever pulls them low or releases them.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 29 ++
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame length and common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_LED   = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE  = 8'hFA;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronizer for one raw PS/2 pin, with falling-edge detection on the synchronized value.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], pin};
  end

  // Lines idle high, so resetting to ones cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift under the device clock, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] RTS_LAST = TW'(RTS_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_DATA_FALL = 4'd8;
  localparam logic [3:0]    STOP_FALL      = 4'(PS2_FRAME_BITS - 2);

  ps2_tx_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          clk_low_q, clk_low_d;
  logic          data_low_q, data_low_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic clk_level, clk_fall;
  logic data_level, unused_data_fall;

  ps2_sync_edge u_sync_clk (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_clk),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_data),
    .level (data_level),
    .fall  (unused_data_fall)
  );

  // Line drives are computed for the next state so they come straight out of flops.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (tx_valid) begin
          shift_d   = tx_data;
          parity_d  = odd_parity(tx_data);
          timer_d   = '0;
          bit_cnt_d = '0;
          clk_low_d = 1'b1;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (timer_q == INH_LAST) begin
          timer_d    = '0;
          data_low_d = 1'b1;
          state_d    = RTS;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // Data stays low on leaving RTS: that is the start bit.
      RTS: begin
        if (timer_q == RTS_LAST) begin
          timer_d   = '0;
          clk_low_d = 1'b0;
          state_d   = SHIFT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      SHIFT: begin
        if (clk_fall) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < LAST_DATA_FALL) begin
            data_low_d = ~shift_q[0];
            shift_d    = {1'b0, shift_q[7:1]};
          end else if (bit_cnt_q == LAST_DATA_FALL) begin
            data_low_d = ~parity_q;
          end else if (bit_cnt_q == STOP_FALL) begin
            data_low_d = 1'b0;
            state_d    = ACK;
          end
        end else if (timer_q == TO_LAST) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ACK: begin
        if (clk_fall) begin
          timer_d = '0;
          if (!data_level) begin
            state_d = WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timer_q == TO_LAST) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      WAIT_IDLE: begin
        if (clk_level && data_level) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (clk_fall) begin
          timer_d = '0;
        end else if (timer_q == TO_LAST) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_ready     = (state_q == IDLE);
  assign ps2_clk_low  = clk_low_q;
  assign ps2_data_low = data_low_q;
  assign tx_done      = done_q;
  assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model clocking frames, scoreboard of expected frames and outcomes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int RTSC = 4;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txValid = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txReady, clkLow, dataLow, txDone, txErr;
  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;
  logic       ps2ClkPin, ps2DataPin;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;
  int doneCount   = 0;
  int errCount    = 0;
  int bothCount   = 0;
  int acceptCount = 0;

  typedef struct packed {
    logic [7:0]  data;
    logic [10:0] frame;
  } expect_t;

  expect_t sbQueue[$];

  assign ps2ClkPin  = ~(clkLow | devClkLow);
  assign ps2DataPin = ~(dataLow | devDataLow);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTSC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (txData),
    .tx_valid     (txValid),
    .tx_ready     (txReady),
    .ps2_clk      (ps2ClkPin),
    .ps2_data     (ps2DataPin),
    .ps2_clk_low  (clkLow),
    .ps2_data_low (dataLow),
    .tx_done      (txDone),
    .tx_err       (txErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycleCount++;
    if (!rst && txValid && txReady) acceptCount++;
  end

  always @(negedge clk) begin
    if (txDone) doneCount++;
    if (txErr) errCount++;
    if (txDone && txErr) bothCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frameOf(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic measureInhibit();
    int highCnt = 0;
    int dataCnt = 0;
    int firstData = -1;
    while (clkLow && highCnt < 200) begin
      if (dataLow) begin
        if (firstData < 0) firstData = highCnt;
        dataCnt++;
      end
      highCnt++;
      @(negedge clk);
    end
    checkOutput("inhibit_len", highCnt, INH + RTSC);
    checkOutput("rts_len", dataCnt, RTSC);
    checkOutput("rts_start", firstData, INH);
    checkOutput("start_bit_held", dataLow, 1'b1);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit keepValid, input bit expectFrame);
    @(negedge clk);
    txData  = d;
    txValid = 1'b1;
    if (expectFrame) sbQueue.push_back('{d, frameOf(d)});
    @(negedge clk);
    checkOutput("accept_clk_low", clkLow, 1'b1);
    checkOutput("busy_not_ready", txReady, 1'b0);
    if (!keepValid) txValid = 1'b0;
    measureInhibit();
  endtask

  task automatic deviceClock(input bit giveAck, input int nFalls, output logic [10:0] sampled, output int lastFall);
    sampled  = '1;
    lastFall = 0;
    repeat (10) @(negedge clk);
    sampled[0] = ps2DataPin;
    for (int k = 1; k <= nFalls; k++) begin
      devClkLow = 1'b1;
      lastFall  = cycleCount;
      repeat (HALF) @(negedge clk);
      devClkLow = 1'b0;
      if (k <= 10) sampled[k] = ps2DataPin;
      if (k == 10 && giveAck) begin
        repeat (5) @(negedge clk);
        devDataLow = 1'b1;
        repeat (HALF - 5) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    devDataLow = 1'b0;
  endtask

  task automatic popCompare(input logic [10:0] sampled);
    expect_t e;
    if (sbQueue.size() == 0) begin
      checkOutput("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sbQueue.pop_front();
      checkOutput($sformatf("frame_%02h", e.data), sampled, e.frame);
    end
  endtask

  task automatic waitOutcome(input bit expectDone, input int budget, input bit postCheck, output int seenCycle);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(txDone || txErr) && n < budget);
    seenCycle = cycleCount;
    checkOutput("outcome_seen", (n < budget), 1'b1);
    checkOutput("tx_done", txDone, expectDone);
    checkOutput("tx_err", txErr, !expectDone);
    if (postCheck) begin
      @(negedge clk);
      checkOutput("pulse_cleared", {txDone, txErr}, 2'b00);
      checkOutput("lines_released", {clkLow, dataLow}, 2'b00);
      checkOutput("ready_after", txReady, 1'b1);
    end
  endtask

  task automatic runFull(input logic [7:0] d, input bit giveAck);
    logic [10:0] s;
    int lf, ec;
    applyStimulus(d, 1'b0, 1'b1);
    fork
      deviceClock(giveAck, 11, s, lf);
      waitOutcome(giveAck, 1000, 1'b1, ec);
    join
    popCompare(s);
  endtask

  initial begin
    logic [10:0] s;
    int lf, ec, d0, e0, a0;

    $display("[TB] starting ps2_host_tx bench");
    repeat (3) @(negedge clk);
    checkOutput("reset_clk_low", clkLow, 1'b0);
    checkOutput("reset_data_low", dataLow, 1'b0);
    checkOutput("reset_pulses", {txDone, txErr}, 2'b00);
    checkOutput("reset_ready", txReady, 1'b1);
    txValid = 1'b1;
    txData  = PS2_CMD_RESET;
    @(negedge clk);
    checkOutput("accept_blocked_in_reset", clkLow, 1'b0);
    txValid = 1'b0;
    rst     = 1'b0;

    runFull(PS2_CMD_LED, 1'b1);
    runFull(8'h00, 1'b1);
    runFull(8'h01, 1'b1);
    runFull(8'hA5, 1'b0);

    // Device stalls after four clocks: abort must follow the last fall by the timeout.
    applyStimulus(8'h3C, 1'b0, 1'b0);
    fork
      deviceClock(1'b0, 4, s, lf);
      waitOutcome(1'b0, 1000, 1'b1, ec);
    join
    checkOutput("timeout_delay_window", ((ec - lf) >= TO) && ((ec - lf) <= TO + 6), 1'b1);

    // Reset while bit 5 of 0x5A (a zero, so data is pulled low) is on the line.
    applyStimulus(8'h5A, 1'b0, 1'b0);
    deviceClock(1'b0, 6, s, lf);
    checkOutput("pre_reset_bit5", dataLow, 1'b1);
    d0 = doneCount;
    e0 = errCount;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_lines", {clkLow, dataLow}, 2'b00);
    checkOutput("midrst_ready", txReady, 1'b1);
    checkOutput("midrst_pulses", {txDone, txErr}, 2'b00);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_done", doneCount - d0, 0);
    checkOutput("midrst_no_err", errCount - e0, 0);
    runFull(PS2_CMD_RESET, 1'b1);

    // tx_valid held high: one accept per transfer, data changes while busy ignored.
    a0 = acceptCount;
    @(negedge clk);
    txData  = 8'hF3;
    txValid = 1'b1;
    sbQueue.push_back('{8'hF3, frameOf(8'hF3)});
    @(negedge clk);
    checkOutput("hold_accept_clk_low", clkLow, 1'b1);
    measureInhibit();
    txData = 8'h55;
    fork
      begin
        deviceClock(1'b1, 11, s, lf);
        txData = 8'hF3;
      end
      waitOutcome(1'b1, 1000, 1'b0, ec);
    join
    popCompare(s);
    checkOutput("b2b_ready_at_done", txReady, 1'b1);
    checkOutput("one_accept_first", acceptCount - a0, 1);
    @(negedge clk);
    checkOutput("b2b_clk_low", clkLow, 1'b1);
    checkOutput("second_accept", acceptCount - a0, 2);
    txValid = 1'b0;
    sbQueue.push_back('{8'hF3, frameOf(8'hF3)});
    measureInhibit();
    fork
      deviceClock(1'b1, 11, s, lf);
      waitOutcome(1'b1, 1000, 1'b1, ec);
    join
    popCompare(s);
    checkOutput("accepts_total_hold", acceptCount - a0, 2);

    checkOutput("total_done", doneCount, 6);
    checkOutput("total_err", errCount, 2);
    checkOutput("exclusive_pulses", bothCount, 0);
    checkOutput("sb_drained", sbQueue.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
